mtm_alu_frame_rx: RTL

//  Parametrised serial-frame receiver for the ALU input path; successor to the fixed 32-bit deserializer.

---
 rtl/mtm_alu_frame_rx_if.sv | 36 +++
 rtl/mtm_alu_frame_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_frame_rx_if.sv
// mtm_alu_frame_rx_if: serial input and result-word handshake bundle.
// Ports: sin, out_ready (to receiver); out_valid, b_out, a_out, op_out, err_out, overrun (from receiver).
interface mtm_alu_frame_rx_if #(
    parameter int DATA_W = 32
) ();
    logic              sin;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] b_out;
    logic [DATA_W-1:0] a_out;
    logic [2:0]        op_out;
    logic [2:0]        err_out;
    logic              overrun;

    modport master (
        output sin,
        output out_ready,
        input  out_valid,
        input  b_out,
        input  a_out,
        input  op_out,
        input  err_out,
        input  overrun
    );

    modport slave (
        input  sin,
        input  out_ready,
        output out_valid,
        output b_out,
        output a_out,
        output op_out,
        output err_out,
        output overrun
    );
endinterface

// File: rtl/mtm_alu_frame_rx.sv
// mtm_alu_frame_rx: serial frame receiver; collects B, A and CMD frames,
// checks count/CRC-4/opcode and presents one word on a valid/ready port.
// Ports: clk, rst_n (async, active low), bus (mtm_alu_frame_rx_if.slave):
//   sin in, out_ready in, out_valid/b_out/a_out/op_out/err_out/overrun out.
module mtm_alu_frame_rx #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mtm_alu_frame_rx_if.slave bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int NSLOT  = 2 * NBYTES;
    localparam int CW     = $clog2(NSLOT + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(NSLOT);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NSLOT + 1);

    typedef enum logic [1:0] {
        IDLE,
        TYPE,
        PAYLOAD,
        STOP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
        logic [2:0]        op;
        logic [2:0]        err;
    } word_t;

    function automatic logic [3:0] crc_bit(
        input logic [3:0] c,
        input logic       d
    );
        logic fb;
        fb = d ^ c[3];
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] crc_byte(
        input logic [3:0] c,
        input logic [7:0] d
    );
        logic [3:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = crc_bit(r, d[i]);
        end
        return r;
    endfunction

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              is_cmd;
    logic [CW-1:0]     data_cnt;
    logic              bad_q;
    logic [3:0]        crc_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] a_q;

    word_t             word_q;
    logic              valid_q;
    logic              overrun_q;

    // CRC runs over each stored data byte as it lands, so only the
    // trailing {1'b1, OP} nibble is folded in when the CMD completes.
    logic [2:0] cmd_op;
    logic [3:0] crc_fin;
    logic       err_data;
    logic       err_crc;
    logic       err_op;
    logic [2:0] err_code;

    assign cmd_op = shreg[6:4];

    always_comb begin
        crc_fin = crc_bit(crc_q, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            crc_fin = crc_bit(crc_fin, cmd_op[i]);
        end
    end

    assign err_data = (data_cnt != CNT_FULL) || bad_q || shreg[7];
    assign err_crc  = (crc_fin != shreg[3:0]);
    assign err_op   = !((cmd_op == 3'b000) || (cmd_op == 3'b001) ||
                        (cmd_op == 3'b100) || (cmd_op == 3'b101));

    always_comb begin
        err_code = 3'b000;
        if (err_data) begin
            err_code = 3'b100;
        end else if (err_crc) begin
            err_code = 3'b010;
        end else if (err_op) begin
            err_code = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            is_cmd    <= 1'b0;
            data_cnt  <= '0;
            bad_q     <= 1'b0;
            crc_q     <= '0;
            b_q       <= '0;
            a_q       <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!bus.sin) begin
                        state <= TYPE;
                    end
                end
                TYPE: begin
                    is_cmd  <= bus.sin;
                    bit_cnt <= '0;
                    state   <= PAYLOAD;
                end
                PAYLOAD: begin
                    shreg   <= {shreg[6:0], bus.sin};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    state <= IDLE;
                    if (!bus.sin) begin
                        // Framing error poisons the whole command.
                        bad_q <= 1'b1;
                    end else if (!is_cmd) begin
                        if (data_cnt < CNT_FULL) begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (data_cnt == CW'(i)) begin
                                    b_q[(NBYTES-1-i)*8 +: 8] <= shreg;
                                end
                                if (data_cnt == CW'(NBYTES + i)) begin
                                    a_q[(NBYTES-1-i)*8 +: 8] <= shreg;
                                end
                            end
                            crc_q <= crc_byte(crc_q, shreg);
                        end
                        if (data_cnt != CNT_SAT) begin
                            data_cnt <= data_cnt + CW'(1);
                        end
                    end else begin
                        data_cnt <= '0;
                        bad_q    <= 1'b0;
                        crc_q    <= '0;
                        // Free slot, or the held word leaves this clk.
                        if (!valid_q || bus.out_ready) begin
                            word_q.b   <= b_q;
                            word_q.a   <= a_q;
                            word_q.op  <= cmd_op;
                            word_q.err <= err_code;
                            valid_q    <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.b_out     = word_q.b;
    assign bus.a_out     = word_q.a;
    assign bus.op_out    = word_q.op;
    assign bus.err_out   = word_q.err;
    assign bus.overrun   = overrun_q;
endmodule
